// File: rtl/inv_key_schedule.sv
// Sequential inverse AES-128 key expansion: walks round keys 10..0 one beat per accept.
// Optional macro INV_KS_EMIT_LAST_EN: when defined the round-10 key itself is the first beat.
module inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StEmit = 1'b1;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    unique case (rnd)
      4'd10:   return 8'h36;
      4'd9:    return 8'h1b;
      4'd8:    return 8'h80;
      4'd7:    return 8'h40;
      4'd6:    return 8'h20;
      4'd5:    return 8'h10;
      4'd4:    return 8'h08;
      4'd3:    return 8'h04;
      4'd2:    return 8'h02;
      4'd1:    return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  logic [0:0]   state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnum_q, rnum_d;
  logic         done_q, done_d;

  logic [127:0] step_in, step_out;
  logic [7:0]   step_rcon;
  logic [31:0]  a0, a1, a2, a3, b0, b1, b2, b3, rot, sub;

  // Single shared step: start path in IDLE, key register while emitting.
  always_comb begin
    step_in   = (state_q == StIdle) ? last_key : key_q;
    step_rcon = rcon((state_q == StIdle) ? 4'd10 : rnum_q);
    a0 = step_in[127:96];
    a1 = step_in[95:64];
    a2 = step_in[63:32];
    a3 = step_in[31:0];
    b3 = a3 ^ a2;
    b2 = a2 ^ a1;
    b1 = a1 ^ a0;
    rot = {b3[23:0], b3[31:24]};
    sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    b0 = a0 ^ sub ^ {step_rcon, 24'h0};
    step_out = {b0, b1, b2, b3};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnum_d  = rnum_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StEmit;
`ifdef INV_KS_EMIT_LAST_EN
          key_d   = last_key;
          rnum_d  = 4'd10;
`else
          key_d   = step_out;
          rnum_d  = 4'd9;
`endif
        end
      end
      default: begin
        if (out_ready) begin
          if (rnum_q == 4'd0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            key_d  = step_out;
            rnum_d = rnum_q - 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      rnum_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnum_q  <= rnum_d;
      done_q  <= done_d;
    end
  end

  assign round_key = key_q;
  assign round_num = rnum_q;
  assign out_valid = (state_q == StEmit);
  assign busy      = (state_q == StEmit);
  assign done      = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule; reference round keys come from a forward
// AES-128 key expansion using an S-box derived from GF(2^8) arithmetic.
module tb_inv_key_schedule;

`ifdef INV_KS_EMIT_LAST_EN
  localparam int First = 10;
`else
  localparam int First = 9;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] last_key = '0;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         busy;
  logic         done;

  inv_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .last_key  (last_key),
    .round_key (round_key),
    .round_num (round_num),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   num;
    logic [127:0] key;
  } beat_t;

  beat_t        exp_q[$];
  int           checks = 0;
  int           failures = 0;
  int           ready_mode = 0;
  logic [7:0]   sb[256];
  logic [127:0] ref_rk[11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic start_walk(input logic [127:0] cipher_key);
    expand(cipher_key);
    for (int r = First; r >= 0; r--) exp_q.push_back({4'(r), ref_rk[r]});
    last_key = ref_rk[10];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400; i++) begin
      if (done) return;
      @(posedge clk); #1;
    end
    chk({name, "_done_timeout"}, 128'(done), 128'd1);
  endtask

  task automatic wait_round(input logic [3:0] n, input string name);
    for (int i = 0; i < 400; i++) begin
      if (out_valid && round_num == n) return;
      @(posedge clk); #1;
    end
    chk({name, "_round_timeout"}, 128'(round_num), 128'(n));
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_round_key"}, round_key, 128'd0);
    chk({name, "_round_num"}, 128'(round_num), 128'd0);
    chk({name, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({name, "_busy"}, 128'(busy), 128'd0);
    chk({name, "_done"}, 128'(done), 128'd0);
  endtask

  // out_ready driver: 0 = always high, 1 = 1,0,0 pattern, 2 = random
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       out_ready = (ph == 0);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      ph = (ph + 1) % 3;
    end
  end

  // Monitor: pops expectations on accepted beats, checks stall stability and done timing.
  initial begin
    logic         prev_stall = 1'b0;
    logic         final_prev = 1'b0;
    logic [127:0] pk = '0;
    logic [3:0]   pn = '0;
    beat_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        final_prev = 1'b0;
      end else begin
        chk("done_timing", 128'(done), 128'(final_prev));
        chk("busy_eq_valid", 128'(busy), 128'(out_valid));
        final_prev = 1'b0;
        if (prev_stall) begin
          chk("stall_valid", 128'(out_valid), 128'd1);
          chk("stall_key", round_key, pk);
          chk("stall_num", 128'(round_num), 128'(pn));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 128'(round_num), 128'hffff);
          end else begin
            e = exp_q.pop_front();
            chk("beat_num", 128'(round_num), 128'(e.num));
            chk("beat_key", round_key, e.key);
            final_prev = (e.num == 4'd0);
          end
        end
        prev_stall = out_valid && !out_ready;
        pk = round_key;
        pn = round_num;
      end
    end
  end

  initial begin
    logic [127:0] fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    init_sbox();
    expand(fips);
    chk("model_rk10", ref_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_rk9", ref_rk[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("model_rk1", ref_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);

    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS walk, no stalls; first beat must appear one cycle after start
    ready_mode = 0;
    start_walk(fips);
    chk("first_beat_valid", 128'(out_valid), 128'd1);
    chk("first_beat_num", 128'(round_num), 128'(First));
    wait_done("fips");
    @(posedge clk); #1;

    // Backpressure pattern, same key
    ready_mode = 1;
    start_walk(fips);
    wait_done("bp");
    @(posedge clk); #1;

    // start while busy must be ignored
    ready_mode = 2;
    start_walk({$urandom, $urandom, $urandom, $urandom});
    wait_round(4'd5, "busy_start");
    last_key = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start");
    repeat (15) @(posedge clk);
    #1;
    chk("no_restart_busy", 128'(busy), 128'd0);

    // Mid-walk reset
    start_walk({$urandom, $urandom, $urandom, $urandom});
    wait_round(4'd6, "midrst");
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_state("midrst");
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    start_walk({$urandom, $urandom, $urandom, $urandom});
    wait_done("after_rst");

    // Back-to-back: next start issued in the done cycle
    ready_mode = 0;
    start_walk({$urandom, $urandom, $urandom, $urandom});
    wait_done("b2b_a");
    start_walk({$urandom, $urandom, $urandom, $urandom});
    chk("b2b_first_valid", 128'(out_valid), 128'd1);
    chk("b2b_first_num", 128'(round_num), 128'(First));
    wait_done("b2b_b");

    // Random keys with random backpressure
    ready_mode = 2;
    for (int k = 0; k < 4; k++) begin
      start_walk({$urandom, $urandom, $urandom, $urandom});
      wait_done("rand");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
